sync_tx_fifo: RTL and testbench

Transmit-side elastic buffer in the clk_tx domain, directly upstream of the two-flop four-phase synchronizer. It accepts words from a local producer at up to one per cycle and presents them one at a time on the synchronizer's data/valid inputs. A word is released only when the synchronizer is not full, which absorbs the multi-cycle handshake round-trip without stalling the producer. It also flags any word dropped by writing into a full buffer.

---
 rtl/sync_tx_fifo_pkg.sv | 9 +
 rtl/sync_tx_fifo_if.sv | 21 ++
 rtl/sync_tx_fifo_mem.sv | 24 ++
 rtl/sync_tx_fifo.sv | 74 +++++++
 tb/tb_sync_tx_fifo.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sync_tx_fifo_pkg.sv
// Shared widths and types for the transmit-side elastic buffer.
// Also holds the shared data-word MSB and the default buffer depth.
package sync_tx_fifo_pkg;
  localparam int unsigned DATA_MSB        = 7;
  localparam int unsigned FIFO_DEPTH_LOG2 = 2;
  localparam int unsigned DATA_W          = DATA_MSB + 1;

  typedef logic [DATA_MSB:0] word_t;
endpackage

// File: rtl/sync_tx_fifo_if.sv
// Producer-side write bus and synchronizer-side data/valid bus.
// Master drives the request half of each bus.
interface sync_tx_wr_if;
  import sync_tx_fifo_pkg::*;
  logic  wr_en;
  word_t wr_data;
  logic  wr_full;

  modport master (output wr_en, output wr_data, input  wr_full);
  modport slave  (input  wr_en, input  wr_data, output wr_full);
endinterface

interface sync_tx_sync_if;
  import sync_tx_fifo_pkg::*;
  word_t out_data;
  logic  v;
  logic  f;

  modport master (output out_data, output v, input  f);
  modport slave  (input  out_data, input  v, output f);
endinterface

// File: rtl/sync_tx_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem
  import sync_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  word_t                 wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output word_t                 rdata_c
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  word_t mem_q [DEPTH];

  // Storage is not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[raddr_i];
endmodule

// File: rtl/sync_tx_fifo.sv
// Transmit-domain elastic buffer feeding the four-phase synchronizer;
// releases the head word whenever the synchronizer is not busy.
module sync_tx_fifo
  import sync_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  sync_tx_wr_if.slave         wr,
  sync_tx_sync_if.master      tx,
  output logic [DEPTH_LOG2:0] count,
  output logic                ovf
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  ovf_q,    ovf_d;

  logic  full_c, v_c, push_c, pop_c;
  word_t rdata_c;

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign v_c    = (count_q != '0);
  assign push_c = wr.wr_en & ~full_c;
  assign pop_c  = v_c & ~tx.f;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr.wr_en & full_c);
    if (push_c) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .we_i    (push_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_c (rdata_c)
  );

  // Head word is masked to zero while empty so stale storage never leaks out.
  assign tx.out_data = v_c ? rdata_c : '0;
  assign tx.v        = v_c;
  assign wr.wr_full  = full_c;
  assign count       = count_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_sync_tx_fifo.sv
// Scoreboard bench for sync_tx_fifo: directed writes push expected words,
// a negedge monitor checks every handoff in order.
module tb_sync_tx_fifo;
  import sync_tx_fifo_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  word_t exp_q[$];

  sync_tx_wr_if   wr_bus ();
  sync_tx_sync_if tx_bus ();

  sync_tx_fifo #(.DEPTH_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_bus.slave),
    .tx    (tx_bus.master),
    .count (count),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Handoff happens on the next posedge when v=1 and f=0; inputs are stable here.
  always @(negedge clk) begin
    if (reset && tx_bus.v && !tx_bus.f) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handoff: got unexpected word 0x%0h required none", tx_bus.out_data);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (tx_bus.out_data !== e) begin
          errors++;
          $display("FAIL handoff: got 0x%0h required 0x%0h", tx_bus.out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input word_t d, input logic fv, input logic accept);
    wr_bus.wr_en   = en;
    wr_bus.wr_data = d;
    tx_bus.f       = fv;
    if (en && accept) exp_q.push_back(d);
    tick();
  endtask

  task automatic idle(input logic fv, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, fv, 1'b0);
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_data = '0;
    tx_bus.f       = 1'b0;
    tick();
    tick();
    check("rst_v",       32'(tx_bus.v),        32'h0);
    check("rst_out",     32'(tx_bus.out_data), 32'h0);
    check("rst_full",    32'(wr_bus.wr_full),  32'h0);
    check("rst_count",   32'(count),           32'h0);
    check("rst_ovf",     32'(ovf),             32'h0);
    reset = 1'b1;
    tick();

    // Three back-to-back words, f=0: latency 1, one handoff per cycle.
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    check("t1_v_lat1",   32'(tx_bus.v),        32'h1);
    check("t1_head",     32'(tx_bus.out_data), 32'h11);
    check("t1_count1",   32'(count),           32'h1);
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    check("t1_head2",    32'(tx_bus.out_data), 32'h22);
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    check("t1_head3",    32'(tx_bus.out_data), 32'h33);
    idle(1'b0, 1);
    check("t1_count0",   32'(count),           32'h0);
    check("t1_v0",       32'(tx_bus.v),        32'h0);
    check("t1_out0",     32'(tx_bus.out_data), 32'h0);

    // f held busy: fill to 4, fifth word dropped and ovf set, then drain 4.
    for (int i = 0; i < 4; i++) drive(1'b1, word_t'(8'hA0 + i), 1'b1, 1'b1);
    check("t2_count4",   32'(count),           32'h4);
    check("t2_full",     32'(wr_bus.wr_full),  32'h1);
    check("t2_ovf_pre",  32'(ovf),             32'h0);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    check("t2_ovf",      32'(ovf),             32'h1);
    check("t2_count_hold", 32'(count),         32'h4);
    idle(1'b0, 4);
    check("t2_drained",  32'(count),           32'h0);
    check("t2_ovf_sticky", 32'(ovf),           32'h1);

    // Full plus simultaneous write and pop: pop wins, write rejected.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, word_t'(8'hB0 + i), 1'b1, 1'b1);
    drive(1'b1, 8'hBF, 1'b0, 1'b0);
    check("t3_count3",   32'(count),           32'h3);
    check("t3_ovf",      32'(ovf),             32'h1);
    check("t3_not_full", 32'(wr_bus.wr_full),  32'h0);
    idle(1'b0, 3);
    check("t3_drained",  32'(count),           32'h0);

    // Pointer wrap at occupancy 2: ten words pass indices 3->0 twice.
    do_reset();
    drive(1'b1, 8'hC0, 1'b1, 1'b1);
    drive(1'b1, 8'hC1, 1'b1, 1'b1);
    for (int i = 2; i < 10; i++) begin
      drive(1'b1, word_t'(8'hC0 + i), 1'b0, 1'b1);
      check("t4_occ2",   32'(count),           32'h2);
    end
    idle(1'b0, 2);
    check("t4_drained",  32'(count),           32'h0);

    // f toggling every cycle during a 6-word burst and its drain.
    for (int k = 0; k < 6; k++) drive(1'b1, word_t'(8'hD0 + k), ((k % 2) == 0), 1'b1);
    check("t5_count3",   32'(count),           32'h3);
    for (int k = 0; k < 6; k++) idle(((k % 2) == 0), 1);
    check("t5_drained",  32'(count),           32'h0);
    check("t5_sb_empty", 32'(exp_q.size()),    32'h0);

    // Asynchronous reset with count=2, ovf=1, then latency-1 write after release.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, word_t'(8'hE0 + i), 1'b1, 1'b1);
    drive(1'b1, 8'hE4, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t6_pre_count", 32'(count),          32'h2);
    check("t6_pre_ovf",  32'(ovf),             32'h1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_v",     32'(tx_bus.v),        32'h0);
    check("t6_async_count", 32'(count),           32'h0);
    check("t6_async_ovf",   32'(ovf),             32'h0);
    check("t6_async_out",   32'(tx_bus.out_data), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, 8'hF0, 1'b0, 1'b1);
    check("t6_v_lat1",   32'(tx_bus.v),        32'h1);
    check("t6_head",     32'(tx_bus.out_data), 32'hF0);
    idle(1'b0, 2);
    check("t6_drained",  32'(count),           32'h0);
    check("sb_empty",    32'(exp_q.size()),    32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
